seq_gen: RTL and testbench
==========================

// Module: seq_gen
// PURPOSE
//   Upstream source for the 8-digit display stage.
//   - Generates a decimal sequence value data_2 (0..9999) at a programmable rate.
//   - Presents the latched program number prog and rate select modulo alongside it.
//   - All three outputs are registered and connect directly to the display block's data_2/prog/modulo inputs.
// PARAMETERS
//   TICK_CYCLES  100_000_000  clk cycles per step at modulo=0 (1 s @ 100 MHz); must be >= 32
// PORTS
//   clk      in   1   system clock, all logic on rising edge
//   rst      in   1   synchronous reset, active-high
//   load     in   1   1-cycle pulse: latch prog_in/mod_in, restart sequence
//   pause    in   1   level: 1 freezes the sequence, 0 lets it run
//   prog_in  in   3   requested program (valid 0..5)
//   mod_in   in   2   requested rate select
//   prog     out  3   latched program, to display
//   modulo   out  2   latched rate select, to display
//   data_2   out  16  current sequence value, binary, always <= 9999
//   running  out  1   1 while FSM is in RUN
//   err      out  1   1 while FSM is in ERR
// BEHAVIOUR
//   Reset:
//   - FSM=IDLE; prog=0, modulo=0, data_2=0, running=0, err=0.
//   - Tick counter=0; Fibonacci/square helper registers=0.
//   Step period: P = TICK_CYCLES >> modulo (modulo 0..3 -> 1, 1/2, 1/4, 1/8 of TICK_CYCLES).
//   Tick counter:
//   - Increments only in RUN.
//   - At count P-1: wraps to 0, and data_2 advances on that same edge.
//   - Holds its value in PAUSE; clears on load.
//   FSM states and transitions:
//   - IDLE: outputs hold; waits for load.
//   - On load (any state, highest priority):
//     - prog<=prog_in, modulo<=mod_in, data_2<=initial value; visible the next cycle.
//     - Next state: ERR if prog_in>5; else PAUSE if pause=1; else RUN.
//   - RUN -> PAUSE when pause=1; PAUSE -> RUN when pause=0.
//   - ERR: data_2=0, err=1, no stepping; left only by load or rst.
//   - pause is ignored in IDLE and ERR.
//   Programs (initial value -> next; on wrap, restart at initial):
//   - 0 up:    0 -> +1;  after 9999 -> 0
//   - 1 down:  9999 -> -1;  after 0 -> 9999
//   - 2 fib:   0,1,1,2,3,5..6765; next term >9999 -> restart 0,1. Helper b holds the next term.
//   - 3 even:  0 -> +2;  after 9998 -> 0
//   - 4 odd:   1 -> +2;  after 9999 -> 1
//   - 5 square: 0,1,4..9801. Incremental sq += 2n+1, no multiplier; after 99^2 -> 0.
//   Arithmetic:
//   - Internal sums use 17 bits. The limit compare (>9999) happens before the register update.
//   - data_2 never exceeds 9999.
//   Simultaneous events: load together with the tick edge -> load wins and the tick is discarded.
//   Reset mid-operation: rst overrides load/pause and returns all state to reset values in one cycle.
// CONFIGURATION
//   SEQ_GEN_BCD_EN defined:
//   - Adds ports data_bcd out 16 (packed 4-digit BCD of data_2) and bcd_valid out 1.
//   - Sequential double-dabble converter, 16 iterations, starts on every data_2 change.
//   - bcd_valid drops the cycle after data_2 changes and rises 17 cycles later.
//   - data_bcd holds its last result while converting.
//   - Reset: data_bcd=0, bcd_valid=1.
//   SEQ_GEN_BCD_EN undefined: ports and converter are absent; behaviour otherwise identical.
// TESTING (TICK_CYCLES=32)
//   1. rst 2 cycles -> prog=0, modulo=0, data_2=0, running=0, err=0.
//   2. load prog_in=0 mod_in=0, pause=0.
//      -> data_2=0 next cycle, running=1; data_2=1 after 32 cycles, =2 after 64.
//      Preset data_2=9999 via sequence -> next step 0.
//   3. load prog_in=2 mod_in=3 -> steps every 4 cycles: 0,1,1,2,3,5,8. After 6765 -> 0, then 1.
//   4. load prog_in=1; pause=1 for 100 cycles -> data_2 frozen at 9999 or 9998, running=0.
//      pause=0 -> counting resumes with the remaining period.
//   5. load prog_in=6 -> err=1, data_2=0, prog=6, no steps for 200 cycles.
//      load prog_in=4 -> err=0, data_2=1.
//   6. load on the same edge as a tick -> restart at initial value, no step.
//      rst mid-RUN -> all outputs to reset values.
//      With SEQ_GEN_BCD_EN: data_2=1234 -> data_bcd=16'h1234 with bcd_valid=1 within 17 cycles.

Source files
------------

// File: rtl/seq_gen.sv
// ---------------------------------------------------------------------------
// seq_gen
//   Feeds the 8-digit display stage. Produces a decimal sequence value data_2
//   (0..9999) that advances once per step period. The latched program number
//   and rate select are presented alongside the value. All outputs come from
//   registers.
//
//   Step period P = TICK_CYCLES >> modulo. The tick counter runs only in RUN.
//   When the counter reaches P-1 it wraps to 0 and data_2 advances on that
//   same edge.
//
//   Programs (initial value, then step rule; restart at initial on wrap):
//     0 up      0,    +1, wraps after 9999
//     1 down    9999, -1, wraps after 0
//     2 fib     0,1,1,2,...,6765, then 0,1 again
//     3 even    0,    +2, wraps after 9998
//     4 odd     1,    +2, wraps after 9999
//     5 square  0,1,4,...,9801, then 0 again
//     6,7       rejected: FSM goes to ERR
//
// Ports
//   clk       in   1   system clock, rising edge
//   rst       in   1   synchronous reset, active-high
//   load      in   1   pulse: latch prog_in/mod_in, restart the sequence
//   pause     in   1   level: freezes stepping (RUN <-> PAUSE)
//   prog_in   in   3   requested program
//   mod_in    in   2   requested rate select
//   prog      out  3   latched program
//   modulo    out  2   latched rate select
//   data_2    out  16  current sequence value, binary, <= 9999
//   running   out  1   FSM is in RUN
//   err       out  1   FSM is in ERR
//
// Optional build macro SEQ_GEN_BCD_EN
//   This macro adds the ports data_bcd (out 16) and bcd_valid (out 1).
//   It also adds a sequential double-dabble converter.
//   - A change of data_2 restarts the converter.
//   - bcd_valid is low for 17 cycles while a conversion runs.
//   - data_bcd keeps the previous result until the new conversion ends.
//
// Control: load is a single-cycle strobe with no handshake. It has the
// highest priority after rst. On a tick edge it wins and the step is
// discarded.
// ---------------------------------------------------------------------------
module seq_gen #(
    parameter int unsigned TICK_CYCLES = 100_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        pause,
    input  logic [2:0]  prog_in,
    input  logic [1:0]  mod_in,
    output logic [2:0]  prog,
    output logic [1:0]  modulo,
    output logic [15:0] data_2,
    output logic        running,
    output logic        err
`ifdef SEQ_GEN_BCD_EN
    ,
    output logic [15:0] data_bcd,
    output logic        bcd_valid
`endif
);

    localparam int unsigned CW     = $clog2(TICK_CYCLES);
    localparam logic [31:0] TICK_W = 32'(TICK_CYCLES);
    localparam logic [16:0] LIMIT  = 17'd9999;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_ERR   = 2'd3
    } state_t;

    // Internal FSM state; checkers can bind to it by hierarchical name.
    state_t state, state_nx;

    logic [CW-1:0] tick_cnt;
    logic [31:0]   tick_last;
    logic          tick;

    // Fibonacci helper: holds the term after data_2. It can reach 10946,
    // so the restart decision is made on the stored term itself.
    logic [16:0]   fib_b;
    // Square helper: n such that data_2 == n*n.
    logic [6:0]    sq_n;

    logic [16:0]   d17;
    logic [16:0]   sum_db;
    logic [16:0]   sum_sq;
    logic [15:0]   data_nx;
    logic [16:0]   fib_b_nx;
    logic [6:0]    sq_n_nx;
    logic [15:0]   init_val;

    assign tick_last = (TICK_W >> modulo) - 32'd1;
    assign tick      = (state == S_RUN) && (32'(tick_cnt) == tick_last);

    assign running = (state == S_RUN);
    assign err     = (state == S_ERR);

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        if (load) begin
            if (prog_in > 3'd5) begin
                state_nx = S_ERR;
            end else if (pause) begin
                state_nx = S_PAUSE;
            end else begin
                state_nx = S_RUN;
            end
        end else begin
            case (state)
                S_RUN:   state_nx = pause ? S_PAUSE : S_RUN;
                S_PAUSE: state_nx = pause ? S_PAUSE : S_RUN;
                default: state_nx = state;
            endcase
        end
    end

    // ---------------- step arithmetic ----------------
    always_comb begin
        d17      = {1'b0, data_2};
        sum_db   = d17 + fib_b;
        sum_sq   = d17 + {9'd0, sq_n, 1'b1};   // sq + 2n + 1
        data_nx  = 16'd0;
        fib_b_nx = fib_b;
        sq_n_nx  = sq_n;
        case (prog)
            3'd0: data_nx = ((d17 + 17'd1) > LIMIT) ? 16'd0 : data_2 + 16'd1;
            3'd1: data_nx = (data_2 == 16'd0) ? 16'd9999 : data_2 - 16'd1;
            3'd2: begin
                if (fib_b > LIMIT) begin
                    data_nx  = 16'd0;
                    fib_b_nx = 17'd1;
                end else begin
                    data_nx  = fib_b[15:0];
                    fib_b_nx = sum_db;
                end
            end
            3'd3: data_nx = ((d17 + 17'd2) > LIMIT) ? 16'd0 : data_2 + 16'd2;
            3'd4: data_nx = ((d17 + 17'd2) > LIMIT) ? 16'd1 : data_2 + 16'd2;
            3'd5: begin
                if (sum_sq > LIMIT) begin
                    data_nx = 16'd0;
                    sq_n_nx = 7'd0;
                end else begin
                    data_nx = sum_sq[15:0];
                    sq_n_nx = sq_n + 7'd1;
                end
            end
            default: data_nx = 16'd0;
        endcase
    end

    always_comb begin
        case (prog_in)
            3'd1:    init_val = 16'd9999;
            3'd4:    init_val = 16'd1;
            default: init_val = 16'd0;
        endcase
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            prog     <= 3'd0;
            modulo   <= 2'd0;
            data_2   <= 16'd0;
            tick_cnt <= '0;
            fib_b    <= 17'd0;
            sq_n     <= 7'd0;
        end else if (load) begin
            prog     <= prog_in;
            modulo   <= mod_in;
            data_2   <= init_val;
            tick_cnt <= '0;
            fib_b    <= 17'd1;
            sq_n     <= 7'd0;
        end else if (state == S_RUN) begin
            if (tick) begin
                tick_cnt <= '0;
                data_2   <= data_nx;
                fib_b    <= fib_b_nx;
                sq_n     <= sq_n_nx;
            end else begin
                tick_cnt <= tick_cnt + CW'(1);
            end
        end
    end

`ifdef SEQ_GEN_BCD_EN
    // ---------------- binary to BCD (double dabble) ----------------
    logic [15:0] bcd_prev;
    logic [15:0] bcd_bin;
    logic [15:0] bcd_acc;
    logic [4:0]  bcd_cnt;
    logic        bcd_busy;

    function automatic logic [15:0] dd_adjust(input logic [15:0] v);
        logic [15:0] r;
        r = v;
        for (int i = 0; i < 4; i++) begin
            if (r[i*4 +: 4] >= 4'd5) begin
                r[i*4 +: 4] = r[i*4 +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            bcd_prev  <= 16'd0;
            bcd_bin   <= 16'd0;
            bcd_acc   <= 16'd0;
            bcd_cnt   <= 5'd0;
            bcd_busy  <= 1'b0;
            data_bcd  <= 16'd0;
            bcd_valid <= 1'b1;
        end else if (data_2 != bcd_prev) begin
            // A new value restarts the converter, even in mid-conversion.
            bcd_prev  <= data_2;
            bcd_bin   <= data_2;
            bcd_acc   <= 16'd0;
            bcd_cnt   <= 5'd0;
            bcd_busy  <= 1'b1;
            bcd_valid <= 1'b0;
        end else if (bcd_busy) begin
            if (bcd_cnt == 5'd16) begin
                data_bcd  <= bcd_acc;
                bcd_valid <= 1'b1;
                bcd_busy  <= 1'b0;
            end else begin
                {bcd_acc, bcd_bin} <= {dd_adjust(bcd_acc), bcd_bin} << 1;
                bcd_cnt            <= bcd_cnt + 5'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_seq_gen.sv
// ---------------------------------------------------------------------------
// tb_seq_gen
//   Directed test of seq_gen with TICK_CYCLES = 32.
//   Step periods are 32, 16, 8 and 4 cycles for modulo 0..3.
//   Inputs change 1 time unit after a rising edge. Outputs are sampled at
//   the same point, after the edge has settled.
//   If SEQ_GEN_BCD_EN is defined, the BCD ports are also connected and
//   checked.
// ---------------------------------------------------------------------------
module tb_seq_gen;

    localparam int TC = 32;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        load;
    logic        pause;
    logic [2:0]  prog_in;
    logic [1:0]  mod_in;
    logic [2:0]  prog;
    logic [1:0]  modulo;
    logic [15:0] data_2;
    logic        running;
    logic        err;
`ifdef SEQ_GEN_BCD_EN
    logic [15:0] data_bcd;
    logic        bcd_valid;
`endif

    seq_gen #(.TICK_CYCLES(TC)) dut (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .pause    (pause),
        .prog_in  (prog_in),
        .mod_in   (mod_in),
        .prog     (prog),
        .modulo   (modulo),
        .data_2   (data_2),
        .running  (running),
        .err      (err)
`ifdef SEQ_GEN_BCD_EN
        ,
        .data_bcd (data_bcd),
        .bcd_valid(bcd_valid)
`endif
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [15:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [2:0] p, input logic [1:0] m);
        prog_in = p;
        mod_in  = m;
        load    = 1'b1;
        cycles(1);
        load    = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_prog"},    32'(prog),    32'd0);
        check({tag, "_modulo"},  32'(modulo),  32'd0);
        check({tag, "_data"},    32'(data_2),  32'd0);
        check({tag, "_running"}, 32'(running), 32'd0);
        check({tag, "_err"},     32'(err),     32'd0);
    endtask

    // Fibonacci terms up to 6765, then the restart 0,1,1,2.
    int fib_tab[25] = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144, 233,
                        377, 610, 987, 1597, 2584, 4181, 6765, 0, 1, 1, 2};

    // ---------------- stimulus ----------------
    initial begin
        rst     = 1'b1;
        load    = 1'b0;
        pause   = 1'b0;
        prog_in = 3'd0;
        mod_in  = 2'd0;

        // 1. reset
        cycles(2);
        check_reset_outputs("reset");
`ifdef SEQ_GEN_BCD_EN
        check("reset_bcd",       32'(data_bcd),  32'd0);
        check("reset_bcd_valid", 32'(bcd_valid), 32'd1);
`endif
        rst = 1'b0;
        pause = 1'b1;                  // ignored in IDLE
        cycles(3);
        check("idle_data",    32'(data_2),  32'd0);
        check("idle_running", 32'(running), 32'd0);
        pause = 1'b0;

        // 2. up, modulo 0: period 32
        do_load(3'd0, 2'd0);
        check("up_init",    32'(data_2),  32'd0);
        check("up_running", 32'(running), 32'd1);
        check("up_prog",    32'(prog),    32'd0);
        check("up_modulo",  32'(modulo),  32'd0);
        cycles(31);
        check("up_before_tick", 32'(data_2), 32'd0);
        cycles(1);
        check("up_step1", 32'(data_2), 32'd1);
        cycles(32);
        check("up_step2", 32'(data_2), 32'd2);

        // up wrap at modulo 3: period 4
        do_load(3'd0, 2'd3);
        check("upw_modulo", 32'(modulo), 32'd3);
        cycles(4 * 9999);
        check("upw_9999", 32'(data_2), 32'd9999);
        cycles(4);
        check("upw_wrap0", 32'(data_2), 32'd0);
        cycles(4);
        check("upw_wrap1", 32'(data_2), 32'd1);

        // 3. fibonacci every 4 cycles
        do_load(3'd2, 2'd3);
        for (int i = 0; i < 25; i++) exp_q.push_back(16'(fib_tab[i]));
        check("fib_t0", 32'(data_2), 32'(exp_q.pop_front()));
        while (exp_q.size() > 0) begin
            cycles(4);
            check("fib_step", 32'(data_2), 32'(exp_q.pop_front()));
        end

        // 4. down with pause
        do_load(3'd1, 2'd3);
        check("down_init", 32'(data_2), 32'd9999);
        cycles(2);
        pause = 1'b1;
        cycles(1);
        check("pause_running", 32'(running), 32'd0);
        cycles(100);
        check("pause_frozen",     32'(data_2),  32'd9999);
        check("pause_running100", 32'(running), 32'd0);
        pause = 1'b0;
        cycles(1);
        check("resume_running", 32'(running), 32'd1);
        check("resume_hold",    32'(data_2),  32'd9999);
        cycles(1);
        check("resume_remaining", 32'(data_2), 32'd9998);
        cycles(4);
        check("down_next", 32'(data_2), 32'd9997);

        // square: 0,1,4,9,16 ... 9801 -> 0
        do_load(3'd5, 2'd3);
        check("sq_0", 32'(data_2), 32'd0);
        cycles(4);  check("sq_1",  32'(data_2), 32'd1);
        cycles(4);  check("sq_4",  32'(data_2), 32'd4);
        cycles(4);  check("sq_9",  32'(data_2), 32'd9);
        cycles(4);  check("sq_16", 32'(data_2), 32'd16);
        cycles(4 * 95);
        check("sq_9801", 32'(data_2), 32'd9801);
        cycles(4);  check("sq_wrap0", 32'(data_2), 32'd0);
        cycles(4);  check("sq_wrap1", 32'(data_2), 32'd1);

        // even
        do_load(3'd3, 2'd3);
        check("even_0", 32'(data_2), 32'd0);
        cycles(4);  check("even_2", 32'(data_2), 32'd2);
        cycles(4);  check("even_4", 32'(data_2), 32'd4);

        // 5. invalid program -> ERR
        do_load(3'd6, 2'd0);
        check("err_flag",    32'(err),     32'd1);
        check("err_data",    32'(data_2),  32'd0);
        check("err_prog",    32'(prog),    32'd6);
        check("err_running", 32'(running), 32'd0);
        pause = 1'b1;                  // ignored in ERR
        cycles(100);
        pause = 1'b0;
        cycles(100);
        check("err_hold_data", 32'(data_2), 32'd0);
        check("err_hold_flag", 32'(err),    32'd1);
        do_load(3'd4, 2'd3);
        check("odd_err_clear", 32'(err),    32'd0);
        check("odd_1",         32'(data_2), 32'd1);
        cycles(4);
        check("odd_3", 32'(data_2), 32'd3);

        // 6. load on a tick edge: load wins, no step
        do_load(3'd0, 2'd3);
        cycles(4);
        check("tickload_pre", 32'(data_2), 32'd1);
        cycles(3);
        do_load(3'd0, 2'd3);           // lands on the edge where count == 3
        check("tickload_restart", 32'(data_2), 32'd0);
        cycles(3);
        check("tickload_full_period", 32'(data_2), 32'd0);
        cycles(1);
        check("tickload_step", 32'(data_2), 32'd1);

        // reset mid-RUN overrides load and pause
        do_load(3'd4, 2'd2);
        cycles(20);
        rst     = 1'b1;
        load    = 1'b1;
        pause   = 1'b1;
        prog_in = 3'd3;
        cycles(1);
        rst   = 1'b0;
        load  = 1'b0;
        pause = 1'b0;
        check_reset_outputs("midrst");
        cycles(10);
        check("midrst_idle_data", 32'(data_2), 32'd0);

`ifdef SEQ_GEN_BCD_EN
        // BCD of 1234; pausing keeps the value steady during conversion
        do_load(3'd0, 2'd3);
        cycles(4 * 1234);
        check("bcd_bin", 32'(data_2), 32'd1234);
        pause = 1'b1;
        cycles(1);
        check("bcd_valid_drop", 32'(bcd_valid), 32'd0);
        cycles(16);
        check("bcd_valid_still_low", 32'(bcd_valid), 32'd0);
        cycles(1);
        check("bcd_valid_rise", 32'(bcd_valid), 32'd1);
        check("bcd_value",      32'(data_bcd),  32'h1234);
        pause = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
